// File: rtl/fetch_decode_buf.sv
// Two-entry elastic buffer between fetch and decode. Holds {pc, ins} pairs,
// drops them on flush, and pre-decodes the head entry's MIPS fields and targets.
module fetch_decode_buf #(
  parameter logic [31:0] PC_RESET = 32'h00400020
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_ins,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext,
  output logic [31:0] imm_zext,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target,
  output logic [1:0]  count
);

  logic [31:0] r_pc  [2];
  logic [31:0] r_ins [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_push;
  logic        w_pop;

  // in_ready is gated by areset so it drops with reset and rises on release
  assign in_ready  = areset & (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign count     = r_count;

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  // Entry storage, pointers and occupancy; flush empties without touching data
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < 2; i++) begin
        r_pc[i]  <= PC_RESET;
        r_ins[i] <= 32'h0000_0000;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_pc[r_wr_ptr]  <= in_pc;
        r_ins[r_wr_ptr] <= in_ins;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Pre-decode of the head entry; all sums wrap mod 2^32
  always_comb begin
    out_pc        = r_pc[r_rd_ptr];
    out_ins       = r_ins[r_rd_ptr];
    out_pc4       = out_pc + 32'd4;
    opcode        = out_ins[31:26];
    rs            = out_ins[25:21];
    rt            = out_ins[20:16];
    rd            = out_ins[15:11];
    shamt         = out_ins[10:6];
    funct         = out_ins[5:0];
    imm_sext      = {{16{out_ins[15]}}, out_ins[15:0]};
    imm_zext      = {16'h0000, out_ins[15:0]};
    branch_target = out_pc4 + {imm_sext[29:0], 2'b00};
    jump_target   = {out_pc4[31:28], out_ins[25:0], 2'b00};
  end

endmodule

// File: tb/tb_fetch_decode_buf.sv
// Directed scoreboard bench for fetch_decode_buf: accepted pairs are queued and
// compared, with their decoded fields, when decode consumes the head entry.
module tb_fetch_decode_buf;

  logic        clk;
  logic        areset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_ins;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic [31:0] out_pc4;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [1:0]  count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops   = 0;
  logic [63:0] sb_q [$];

  fetch_decode_buf dut (
    .clk           (clk),
    .areset        (areset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_ins        (in_ins),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_ins       (out_ins),
    .out_pc4       (out_pc4),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .shamt         (shamt),
    .funct         (funct),
    .imm_sext      (imm_sext),
    .imm_zext      (imm_zext),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check state against the model, apply the handshake, advance
  task automatic cyc();
    logic [63:0] e;
    logic [31:0] epc;
    logic [31:0] eins;
    logic [31:0] esx;
    logic        m_push;
    logic        m_pop;
    #1;
    if (areset) begin
      chk("count", {30'd0, count}, sb_q.size());
      chk("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, sb_q.size() < 2});
      m_push = in_valid && (sb_q.size() < 2) && !flush;
      m_pop  = (sb_q.size() != 0) && out_ready && !flush;
      if (m_pop) begin
        e    = sb_q.pop_front();
        epc  = e[63:32];
        eins = e[31:0];
        esx  = {{16{eins[15]}}, eins[15:0]};
        n_pops++;
        chk("out_pc", out_pc, epc);
        chk("out_ins", out_ins, eins);
        chk("out_pc4", out_pc4, epc + 32'd4);
        chk("fields", {opcode, rs, rt, rd, shamt, funct},
            {eins[31:26], eins[25:21], eins[20:16], eins[15:11], eins[10:6], eins[5:0]});
        chk("imm_sext", imm_sext, esx);
        chk("branch_target", branch_target, epc + 32'd4 + (esx << 2));
        chk("jump_target", jump_target, {epc[31:28] + ((epc[27:0] + 28'd4 == 28'd0) ? 4'd1 : 4'd0),
                                         eins[25:0], 2'b00});
      end
      if (flush) sb_q.delete();
      else if (m_push) sb_q.push_back({in_pc, in_ins});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    areset    = 1'b0;
    in_valid  = 1'b0;
    in_pc     = 32'h0;
    in_ins    = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Power-on reset values
    chk("rst_out_pc", out_pc, 32'h00400020);
    chk("rst_out_ins", out_ins, 32'h0);
    chk("rst_out_pc4", out_pc4, 32'h00400024);
    chk("rst_branch_target", branch_target, 32'h00400024);
    chk("rst_jump_target", jump_target, 32'h0);
    chk("rst_imm", imm_sext | imm_zext, 32'h0);
    chk("rst_flags", {29'd0, in_ready, out_valid, count != 2'd0}, 32'h0);

    @(negedge clk);
    areset = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);

    // Single push and decode of addi $t0,$t1,-4
    in_valid = 1'b1; in_pc = 32'h00400020; in_ins = 32'h2128FFFC;
    cyc();
    in_valid = 1'b0;
    chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_opcode", {26'd0, opcode}, 32'h08);
    chk("t2_rs", {27'd0, rs}, 32'd9);
    chk("t2_rt", {27'd0, rt}, 32'd8);
    chk("t2_imm_sext", imm_sext, 32'hFFFFFFFC);
    chk("t2_imm_zext", imm_zext, 32'h0000FFFC);
    chk("t2_out_pc4", out_pc4, 32'h00400024);
    chk("t2_branch_target", branch_target, 32'h00400014);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Backpressure: third pair held upstream until a pop frees a slot
    in_valid = 1'b1; in_pc = 32'h00400020; in_ins = 32'h00000020;
    cyc();
    in_pc = 32'h00400024; in_ins = 32'h00000024;
    cyc();
    in_pc = 32'h00400028; in_ins = 32'h00000028;
    cyc();
    chk("t3_full_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    out_ready = 1'b1;
    cyc();
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("t3_pops", n_pops, 32'd4);
    out_ready = 1'b0;

    // Streaming: one transfer per cycle at occupancy 1
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_pc  = 32'h00401000 + 32'(i * 4);
      in_ins = $urandom;
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("t4_pops", n_pops, 32'd12);
    out_ready = 1'b0;

    // Flush while full, then a fresh push is the first output
    in_valid = 1'b1; in_pc = 32'h00400040; in_ins = 32'h11111111;
    cyc();
    in_pc = 32'h00400044; in_ins = 32'h22222222;
    cyc();
    in_pc = 32'h00400048; in_ins = 32'h33333333;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t5_count", {30'd0, count}, 32'd0);
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    in_pc = 32'h00400100; in_ins = 32'h3C010040;
    cyc();
    in_valid = 1'b0;
    chk("t5_head_pc", out_pc, 32'h00400100);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Jump target and pc+4 wrap
    in_valid = 1'b1; in_pc = 32'h00400028; in_ins = 32'h08100008;
    cyc();
    in_valid = 1'b0;
    chk("t6_jump_target", jump_target, 32'h00400020);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'hFFFFFFFC; in_ins = 32'h1000FFFF;
    cyc();
    in_valid = 1'b0;
    chk("t6_pc4_wrap", out_pc4, 32'h00000000);
    chk("t6_branch_wrap", branch_target, 32'hFFFFFFFC);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Reset asserted mid-operation while full
    in_valid = 1'b1; in_pc = 32'h00400200; in_ins = 32'hAAAA5555;
    cyc();
    in_pc = 32'h00400204; in_ins = 32'h5555AAAA;
    cyc();
    in_valid = 1'b0;
    chk("t7_pre_count", {30'd0, count}, 32'd2);
    #2;
    areset = 1'b0;
    #1;
    sb_q.delete();
    chk("t7_count", {30'd0, count}, 32'd0);
    chk("t7_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t7_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t7_out_pc", out_pc, 32'h00400020);
    chk("t7_out_ins", out_ins, 32'h0);
    @(negedge clk);
    areset = 1'b1;
    #1;
    chk("t7_release_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
